// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: state encoding and
// arbitration policy selectors.
package wb_arb_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS0 = 2'd1;
  localparam logic [1:0] ST_BUS1 = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts stalled strobe cycles and pulses expire on the
// cycle the count reaches TIMEOUT. TIMEOUT = 0 disables it.
module wb_arb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expire
);
  import wb_arb_pkg::*;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // expire fires in the stalled cycle that would make the count equal TIMEOUT
  always_comb begin
    expire = (TIMEOUT > 0) && count_en && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clear || expire || (TIMEOUT == 0)) cnt_d = '0;
    else if (count_en)                     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_arbiter_2x1.sv
// Two-master, one-slave Wishbone classic arbiter with a registered grant
// held for the whole bus cycle and an optional no-ack watchdog.
module wb_arbiter_2x1 #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int ARB_TYPE     = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic                    s_ack_i
);
  import wb_arb_pkg::*;

  // Handshake: a master owns the bus while its cyc is high once granted; each
  // stb cycle is a request that completes on the cycle ack (or err) is high.
  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       stb_sel, count_en, wd_clear, expire;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if ((ARB_TYPE == ARB_FIXED) || last_grant_q) state_d = ST_BUS0;
          else                                         state_d = ST_BUS1;
        end else if (m0_cyc_i) begin
          state_d = ST_BUS0;
        end else if (m1_cyc_i) begin
          state_d = ST_BUS1;
        end
        if (state_d == ST_BUS0)      last_grant_d = 1'b0;
        else if (state_d == ST_BUS1) last_grant_d = 1'b1;
      end
      ST_BUS0: if (!m0_cyc_i) state_d = ST_IDLE;
      ST_BUS1: if (!m1_cyc_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    stb_sel = 1'b0;
    case (state_q)
      ST_BUS0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_cyc_o = m0_cyc_i;
        stb_sel = m0_stb_i;
      end
      ST_BUS1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_cyc_o = m1_cyc_i;
        stb_sel = m1_stb_i;
      end
      default: ;
    endcase
  end

  // An ack in the same cycle as a would-be timeout suppresses the error
  assign count_en = stb_sel && !s_ack_i;
  assign wd_clear = s_ack_i || !stb_sel || (state_d != state_q);

  wb_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .count_en(count_en),
    .expire  (expire)
  );

  assign s_stb_o  = stb_sel && !expire;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state_q == ST_BUS0) && s_ack_i;
  assign m1_ack_o = (state_q == ST_BUS1) && s_ack_i;
  assign m0_err_o = (state_q == ST_BUS0) && expire;
  assign m1_err_o = (state_q == ST_BUS1) && expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Bench for wb_arbiter_2x1: a fixed-priority and a round-robin instance share
// the same masters, each with its own RAM slave and reference model.
module tb_wb_arbiter_2x1;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_wd, m1_wd;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  int            slave_mode;  // 0 = registered-ack RAM, 1 = never acks, 2 = random ack/data
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wd = dat; m0_sel = '1;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wd = dat; m1_sel = '1;
    end
  endtask

  task automatic rand_master(inout int len, output logic cyc, output logic stb, output logic we,
                             output logic [AW-1:0] adr, output logic [DW-1:0] dat,
                             output logic [SW-1:0] sel);
    if (len == 0 && $urandom_range(0, 2) == 0) len = $urandom_range(1, 8);
    cyc = (len > 0);
    if (len > 0) len--;
    stb = cyc && ($urandom_range(0, 3) != 0);
    we  = 1'($urandom_range(0, 1));
    adr = $urandom;
    dat = $urandom;
    sel = SW'($urandom);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [DW-1:0] m0_rd, m1_rd, s_wd;
    logic [DW-1:0] s_rd = '0;
    logic [AW-1:0] s_adr;
    logic [SW-1:0] s_sel;
    logic          m0_ack, m0_err, m1_ack, m1_err, s_we, s_stb, s_cyc;
    logic          s_ack = 1'b0;
    logic [DW-1:0] mem [64];
    // reference model: owner -1 = nobody, else master index
    int own = -1, last = 1, wd = 0, own_n = -1, last_n = 1, wd_n = 0;

    wb_arbiter_2x1 #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .ARB_TYPE(g), .TIMEOUT(TMO)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_dat_o(m0_rd), .m0_we_i(m0_we),
      .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_dat_o(m1_rd), .m1_we_i(m1_we),
      .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_wd), .s_dat_i(s_rd), .s_we_o(s_we), .s_sel_o(s_sel),
      .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack)
    );

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    always @(posedge clk) begin
      if (slave_mode == 1) begin
        s_ack <= 1'b0;
      end else if (slave_mode == 2) begin
        s_ack <= 1'($urandom_range(0, 1));
        s_rd  <= $urandom;
      end else begin
        s_ack <= s_stb && !s_ack;
        if (s_stb && !s_ack) begin
          s_rd <= mem[s_adr[7:2]];
          if (s_we)
            for (int b = 0; b < SW; b++)
              if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_wd[8*b +: 8];
        end
      end
    end

    // scoreboard: expected outputs from the model's owner and the live inputs
    always @(negedge clk) begin : model
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_wd;
      logic [SW-1:0] e_sel;
      logic          e_cyc, e_stb, e_we, stall, expire, req;
      int            pick;
      e_adr = '0; e_wd = '0; e_sel = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      if (own == 0) begin
        e_adr = m0_adr; e_wd = m0_wd; e_sel = m0_sel; e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we;
      end else if (own == 1) begin
        e_adr = m1_adr; e_wd = m1_wd; e_sel = m1_sel; e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we;
      end
      stall  = (own >= 0) && e_stb && !s_ack;
      expire = stall && (wd == TMO - 1);
      check($sformatf("i%0d ctrl", g),
            {s_cyc, s_stb, s_we, s_sel, m0_ack, m1_ack, m0_err, m1_err},
            {e_cyc, e_stb && !expire, e_we, e_sel, (own == 0) && s_ack, (own == 1) && s_ack,
             (own == 0) && expire, (own == 1) && expire});
      check($sformatf("i%0d adr", g), s_adr, e_adr);
      check($sformatf("i%0d wdat", g), s_wd, e_wd);
      check($sformatf("i%0d rdat", g), {m0_rd, m1_rd}, {s_rd, s_rd});

      own_n = own; last_n = last; wd_n = 0;
      req = (own == 0) ? m0_cyc : m1_cyc;
      if (own < 0) begin
        pick = -1;
        if (m0_cyc && m1_cyc) pick = (g == 0) ? 0 : 1 - last;
        else if (m0_cyc)      pick = 0;
        else if (m1_cyc)      pick = 1;
        if (pick >= 0) begin own_n = pick; last_n = pick; end
      end else if (!req) begin
        own_n = -1;
      end else if (stall && !expire) begin
        wd_n = wd + 1;
      end
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin own <= -1; last <= 1; wd <= 0; end
      else begin own <= own_n; last <= last_n; wd <= wd_n; end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish, want finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    int first, n_e, acks, len0, len1;
    logic stb_at;
    rst_n = 1'b1;
    slave_mode = 0;
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset idle", {g_inst[0].s_cyc, g_inst[1].s_cyc, g_inst[0].s_stb, g_inst[1].s_stb,
                         g_inst[1].m0_ack, g_inst[1].m1_ack, g_inst[1].m0_err, g_inst[1].m1_err}, 0);
    #2 rst_n = 1'b1;

    // m0 write then read back
    tick(); set_m(0, 1, 1, 1, 32'h10, 32'hDEADBEEF);
    tick(); @(negedge clk); check("wr stb N+1", g_inst[1].s_stb, 1);
    tick(); @(negedge clk); check("wr ack N+2", g_inst[1].m0_ack, 1);
    tick(); set_m(0, 0, 0, 0, '0, '0);
    tick(); set_m(0, 1, 1, 0, 32'h10, '0);
    tick(); @(negedge clk); check("rd stb N+1", g_inst[1].s_stb, 1);
    tick(); @(negedge clk);
    check("rd ack N+2", g_inst[1].m0_ack, 1);
    check("rd data", g_inst[1].m0_rd, 32'hDEADBEEF);
    check("m1 quiet", {g_inst[1].m1_ack, g_inst[0].m1_ack}, 0);
    tick(); set_m(0, 0, 0, 0, '0, '0);
    tick();

    // tie after reset: both grant m0; then round-robin hands the next tie to m1
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tick(); set_m(0, 1, 1, 0, 32'h100, '0); set_m(1, 1, 1, 0, 32'h200, '0);
    tick(); @(negedge clk);
    check("rr first", g_inst[1].s_adr, 32'h100);
    check("fx first", g_inst[0].s_adr, 32'h100);
    tick();
    tick(); set_m(0, 0, 0, 0, 32'h140, '0);
    tick(); set_m(0, 1, 1, 0, 32'h140, '0);
    @(negedge clk); check("idle gap", {g_inst[1].s_cyc, g_inst[0].s_cyc}, 0);
    tick(); @(negedge clk);
    check("rr second", g_inst[1].s_adr, 32'h200);
    check("fx keeps m0", g_inst[0].s_adr, 32'h140);
    set_m(0, 0, 0, 0, '0, '0); set_m(1, 0, 0, 0, '0, '0);
    tick(); tick();

    // fixed priority: m0 wins every tie, m1 served once m0 lets go
    for (int rep = 0; rep < 3; rep++) begin
      tick(); set_m(0, 1, 1, 0, 32'h300 + 32'(rep * 4), '0); set_m(1, 1, 1, 0, 32'h400, '0);
      tick(); @(negedge clk); check("fx tie", g_inst[0].s_adr, 32'h300 + 32'(rep * 4));
      tick(); set_m(0, 0, 0, 0, '0, '0);
      tick(); tick(); @(negedge clk); check("fx m1 served", g_inst[0].s_adr, 32'h400);
      set_m(1, 0, 0, 0, '0, '0);
      tick();
    end

    // watchdog: slave never acks, m1 stalls
    slave_mode = 1;
    tick(); set_m(1, 1, 1, 1, 32'h500, 32'h5A5A);
    first = 0; n_e = 0; acks = 0; stb_at = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(); @(negedge clk);
      if (g_inst[1].m1_err) begin
        n_e++;
        if (first == 0) begin first = i; stb_at = g_inst[1].s_stb; end
      end
      if (g_inst[1].m1_ack) acks++;
    end
    check("tmo first err", 64'(first), 4);
    check("tmo err count", 64'(n_e), 2);
    check("tmo stb low", stb_at, 0);
    check("tmo no ack", 64'(acks), 0);
    set_m(1, 0, 0, 0, '0, '0);
    tick(); slave_mode = 0;
    tick();

    // m0 drops cyc while the RAM is registering its ack
    tick(); set_m(0, 1, 1, 0, 32'h10, '0);
    tick(); m0_cyc = 1'b0;
    tick(); set_m(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("late ack dropped", {g_inst[1].m0_ack, g_inst[1].m1_ack, g_inst[0].m0_ack, g_inst[0].m1_ack}, 0);
    check("late ack idle", g_inst[1].s_cyc, 0);
    tick();

    // asynchronous reset in the middle of a BUS1 cycle
    tick(); set_m(1, 1, 1, 0, 32'h600, '0);
    tick(); @(negedge clk); check("bus1 up", g_inst[1].s_cyc, 1);
    #2 rst_n = 1'b0;
    #1 check("async rst", {g_inst[1].s_cyc, g_inst[1].s_stb, g_inst[0].s_cyc, g_inst[0].s_stb}, 0);
    @(posedge clk); #2;
    set_m(1, 0, 0, 0, '0, '0);
    rst_n = 1'b1;
    tick(); set_m(0, 1, 1, 0, 32'h700, '0); set_m(1, 1, 1, 0, 32'h800, '0);
    tick(); @(negedge clk);
    check("post-rst tie rr", g_inst[1].s_adr, 32'h700);
    check("post-rst tie fx", g_inst[0].s_adr, 32'h700);
    set_m(0, 0, 0, 0, '0, '0); set_m(1, 0, 0, 0, '0, '0);
    tick(); tick();

    // randomized traffic against the reference models
    len0 = 0; len1 = 0;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) slave_mode = $urandom_range(0, 2);
      tick();
      rand_master(len0, m0_cyc, m0_stb, m0_we, m0_adr, m0_wd, m0_sel);
      rand_master(len1, m1_cyc, m1_stb, m1_we, m1_adr, m1_wd, m1_sel);
    end
    set_m(0, 0, 0, 0, '0, '0); set_m(1, 0, 0, 0, '0, '0);
    slave_mode = 0;
    repeat (3) tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
